// File: rtl/data_mem_ctrl.sv
// Load/store sequencer between the CPU datapath and a small data memory.
// Accepts one request per valid/ready handshake, drives the memory control
// lines for LOAD, STORE, read-modify-write ADD and multi-word FILL, and
// returns a single-cycle response pulse when each request completes.
module data_mem_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  input  logic [AW-1:0] req_len,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_carry,
  output logic          mem_en,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_RMW_WR = 3'd3;
  localparam logic [2:0] S_FILL   = 3'd4;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  logic [2:0]    state;
  logic [1:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] cnt_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] temp_q;
  logic [DW:0]   sum;

  // Old value plus addend, one extra bit to expose the carry out.
  assign sum = {1'b0, temp_q} + {1'b0, data_q};

  // Handshake and memory controls are pure decodes of the current state.
  assign req_ready = (state == S_IDLE);
  assign mem_en    = (state == S_RD) || (state == S_WR) ||
                     (state == S_RMW_WR) || (state == S_FILL);
  assign mem_wen   = (state == S_WR) || (state == S_RMW_WR) || (state == S_FILL);
  assign mem_addr  = addr_q;
  assign mem_wdata = (state == S_RMW_WR) ? sum[DW-1:0] : data_q;

  // Sequencer: request latch, per-op state walk and response generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here is a handful of flops, not a memory array,
      // so all of them get a reset value; the controlled memory itself keeps
      // its contents across reset.
      state     <= S_IDLE;
      op_q      <= OP_LOAD;
      addr_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      temp_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // the pre-edge values, independent of statement order.
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            data_q <= req_data;
            cnt_q  <= req_len;
            case (req_op)
              OP_LOAD:  state <= S_RD;
              OP_STORE: state <= S_WR;
              OP_ADD:   state <= S_RD;
              default:  state <= S_FILL;
            endcase
          end
        end
        S_RD: begin
          if (op_q == OP_ADD) begin
            temp_q <= mem_rdata;
            state  <= S_RMW_WR;
          end else begin
            rsp_data  <= mem_rdata;
            rsp_carry <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_WR: begin
          rsp_data  <= data_q;
          rsp_carry <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= S_IDLE;
        end
        S_RMW_WR: begin
          rsp_data  <= temp_q;
          rsp_carry <= sum[DW];
          rsp_valid <= 1'b1;
          state     <= S_IDLE;
        end
        S_FILL: begin
          // Address wraps naturally at 2^AW; count 0 marks the last write.
          addr_q <= addr_q + AW'(1);
          cnt_q  <= cnt_q - AW'(1);
          if (cnt_q == '0) begin
            rsp_data  <= data_q;
            rsp_carry <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl with a behavioural 16x8 memory.
module tb_data_mem_ctrl;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] len;
    logic [7:0] exp_data;
    logic       exp_carry;
    int         exp_lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_addr;
  logic [7:0] req_data;
  logic [3:0] req_len;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       mem_en;
  logic       mem_wen;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [16];

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  data_mem_ctrl #(.AW(4), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, synchronous write.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_en && mem_wen) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"},  rsp_data, 0);
    check({tag, "_rsp_carry"}, rsp_carry, 0);
    check({tag, "_mem_en"},    mem_en, 0);
    check({tag, "_mem_wen"},   mem_wen, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Issue one request, then follow it to its response, checking per-cycle
  // memory activity, busy handshake, latency and response fields.
  task automatic run_req(input vec_t v);
    int lat;
    logic wen_seen;
    logic [3:0] ea;
    lat = 0;
    wen_seen = 1'b0;
    @(negedge clk);
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_addr  = v.addr;
    req_data  = v.data;
    req_len   = v.len;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = ~v.addr;
    req_data  = ~v.data;
    req_len   = ~v.len;
    req_op    = ~v.op;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
      check("busy_ready", req_ready, 0);
      if (mem_wen) wen_seen = 1'b1;
      if (v.op == OP_FILL) begin
        ea = v.addr + 4'(k - 1);
        check("fill_wen",   mem_wen, 1);
        check("fill_addr",  mem_addr, ea);
        check("fill_wdata", mem_wdata, v.data);
      end
      if (v.op == OP_STORE) begin
        check("store_addr",  mem_addr, v.addr);
        check("store_wdata", mem_wdata, v.data);
      end
    end
    check("latency",   lat, v.exp_lat);
    check("rsp_data",  rsp_data, v.exp_data);
    check("rsp_carry", rsp_carry, v.exp_carry);
    check("rsp_ready", req_ready, 1);
    if (v.op == OP_LOAD) check("load_no_wen", wen_seen, 0);
    @(negedge clk);
    check("rsp_pulse", rsp_valid, 0);
  endtask

  initial begin
    logic [3:0] b2b_op_addr;
    logic [7:0] b2b_exp [6];
    int acc_cyc [6];
    int idx;
    int resp;
    int fill_rsp;
    logic rdy;

    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);

    req_valid = 1'b0;
    req_op    = OP_LOAD;
    req_addr  = '0;
    req_data  = '0;
    req_len   = '0;
    rst_n     = 1'b0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("post_por");

    // Reset in the middle of FILL addr 0 len 7 after three writes.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_FILL;
    req_addr  = 4'd0;
    req_data  = 8'h5A;
    req_len   = 4'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    fill_rsp = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      if (rsp_valid) fill_rsp++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_fill");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) fill_rsp++;
    end
    check("abort_no_rsp", fill_rsp, 0);
    for (int i = 0; i < 3; i++) check("abort_written", mem[i], 8'h5A);
    for (int i = 3; i < 8; i++) check("abort_untouched", mem[i], 8'(i * 17));

    // Directed request table with hand-computed responses.
    vecs.push_back('{OP_STORE, 4'd3,  8'hA5, 4'd0,  8'hA5, 1'b0, 2});
    vecs.push_back('{OP_LOAD,  4'd3,  8'h00, 4'd0,  8'hA5, 1'b0, 2});
    vecs.push_back('{OP_STORE, 4'd7,  8'hF0, 4'd0,  8'hF0, 1'b0, 2});
    vecs.push_back('{OP_ADD,   4'd7,  8'h20, 4'd0,  8'hF0, 1'b1, 3});
    vecs.push_back('{OP_LOAD,  4'd7,  8'h00, 4'd0,  8'h10, 1'b0, 2});
    vecs.push_back('{OP_ADD,   4'd7,  8'h05, 4'd0,  8'h10, 1'b0, 3});
    vecs.push_back('{OP_LOAD,  4'd7,  8'h00, 4'd0,  8'h15, 1'b0, 2});
    vecs.push_back('{OP_LOAD,  4'd2,  8'h00, 4'd0,  8'h5A, 1'b0, 2});
    vecs.push_back('{OP_LOAD,  4'd5,  8'h00, 4'd0,  8'h55, 1'b0, 2});
    vecs.push_back('{OP_FILL,  4'd14, 8'h3C, 4'd3,  8'h3C, 1'b0, 5});
    vecs.push_back('{OP_LOAD,  4'd14, 8'h00, 4'd0,  8'h3C, 1'b0, 2});
    vecs.push_back('{OP_LOAD,  4'd15, 8'h00, 4'd0,  8'h3C, 1'b0, 2});
    vecs.push_back('{OP_LOAD,  4'd0,  8'h00, 4'd0,  8'h3C, 1'b0, 2});
    vecs.push_back('{OP_LOAD,  4'd1,  8'h00, 4'd0,  8'h3C, 1'b0, 2});
    vecs.push_back('{OP_LOAD,  4'd2,  8'h00, 4'd0,  8'h5A, 1'b0, 2});
    vecs.push_back('{OP_FILL,  4'd4,  8'h99, 4'd0,  8'h99, 1'b0, 2});
    vecs.push_back('{OP_LOAD,  4'd4,  8'h00, 4'd0,  8'h99, 1'b0, 2});
    vecs.push_back('{OP_LOAD,  4'd5,  8'h00, 4'd0,  8'h55, 1'b0, 2});
    vecs.push_back('{OP_STORE, 4'd6,  8'hFF, 4'd0,  8'hFF, 1'b0, 2});
    vecs.push_back('{OP_ADD,   4'd6,  8'h01, 4'd0,  8'hFF, 1'b1, 3});
    vecs.push_back('{OP_LOAD,  4'd6,  8'h00, 4'd0,  8'h00, 1'b0, 2});
    vecs.push_back('{OP_FILL,  4'd8,  8'hC3, 4'd15, 8'hC3, 1'b0, 17});
    vecs.push_back('{OP_LOAD,  4'd0,  8'h00, 4'd0,  8'hC3, 1'b0, 2});
    vecs.push_back('{OP_LOAD,  4'd7,  8'h00, 4'd0,  8'hC3, 1'b0, 2});

    foreach (vecs[i]) run_req(vecs[i]);

    // Back-to-back STORE/LOAD to addr 9 with req_valid held high.
    b2b_op_addr = 4'd9;
    b2b_exp[0] = 8'h61; b2b_exp[1] = 8'h61;
    b2b_exp[2] = 8'h62; b2b_exp[3] = 8'h62;
    b2b_exp[4] = 8'h63; b2b_exp[5] = 8'h63;
    idx  = 0;
    resp = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_STORE;
    req_addr  = b2b_op_addr;
    req_data  = b2b_exp[0];
    req_len   = 4'd0;
    for (int c = 0; c < 40 && resp < 6; c++) begin
      if (c > 0) @(negedge clk);
      rdy = req_ready;
      if (rsp_valid) begin
        check("b2b_rsp_data", rsp_data, b2b_exp[resp]);
        resp++;
      end
      if (rdy && idx < 6) acc_cyc[idx] = c;
      @(posedge clk);
      #1;
      if (rdy && idx < 6) begin
        idx++;
        if (idx < 6) begin
          req_op   = idx[0] ? OP_LOAD : OP_STORE;
          req_data = b2b_exp[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    check("b2b_all_rsp", resp, 6);
    check("b2b_all_acc", idx, 6);
    for (int i = 1; i < 6; i++) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 2);
    check("b2b_mem9", mem[9], 8'h63);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Load/store sequencer between the CPU datapath and the 16x8 data memory (combinational read, synchronous write on posedge when enable and write-enable are both high).
- Accepts one request per valid/ready handshake and drives the memory enable, write-enable, address and write-data lines.
- Executes LOAD, STORE, read-modify-write ADD and multi-word FILL, returning a one-cycle response pulse.

Parameters:
- AW, 4, memory address width; also the FILL length width.
- DW, 8, data width.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request; high only in IDLE.
- req_op  input  2  00 LOAD, 01 STORE, 10 ADD, 11 FILL.
- req_addr  input  AW  start address.
- req_data  input  DW  store data, addend, or fill value.
- req_len  input  AW  FILL word count minus 1; ignored for other ops.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_data  output  DW  response data; held until the next response.
- rsp_carry  output  1  carry out of ADD; 0 for other ops.
- mem_en  output  1  memory enable.
- mem_wen  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, combinational from mem_addr.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rsp_valid=0, rsp_data=0, rsp_carry=0.
  - Latched op/addr/data/count are cleared to 0, so mem_addr=0 and mem_wdata=0.
  - mem_en=0, mem_wen=0, req_ready=1 (as soon as rst_n is deasserted).
- Reset mid-operation aborts immediately. Writes already completed stay in memory; no response is issued.
- States: IDLE, RD, WR, RMW_WR, FILL.
- Memory outputs (decoded from state, no extra pipeline):
  - mem_en=1 in RD, WR, RMW_WR and FILL; 0 otherwise.
  - mem_wen=1 in WR, RMW_WR and FILL only.
  - mem_addr and mem_wdata come from the latched registers.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid=1, latch op, addr, data and len.
  - Next state by op: LOAD->RD, STORE->WR, ADD->RD, FILL->FILL.
  - req_ready=0 in every non-IDLE state; req_valid there is ignored and not queued.
- LOAD: in RD, capture mem_rdata into rsp_data at the edge ending the cycle, then go to IDLE.
  - Accept at edge N; RD during cycle N+1; rsp_valid=1 in cycle N+2 together with req_ready=1.
- STORE:
  - WR writes data at addr (the memory commits at the edge ending the WR cycle), then IDLE.
  - rsp_data=written data, rsp_valid in cycle N+2.
- ADD:
  - RD captures the old value into a temp register.
  - RMW_WR writes (temp+data) mod 2^DW.
  - rsp_data=old value, rsp_carry=carry out of the DW-bit sum.
  - rsp_valid in cycle N+3.
- FILL:
  - Writes data to len+1 consecutive addresses, one per cycle, starting at addr.
  - Address increments mod 2^AW (15 wraps to 0).
  - The count decrements each cycle; the FILL write whose count is 0 is the last one, then IDLE.
  - rsp_data=fill value; rsp_valid in the cycle after the last write.
  - Latency: len+2 cycles from the accept edge to rsp_valid.
  - len=15 writes all 16 locations.
- rsp_valid:
  - High exactly one cycle per completed request.
  - No response backpressure; the consumer must take rsp_data in that cycle.
  - A new request may be accepted in the same cycle rsp_valid is high.
- Back-to-back: continuous req_valid yields one accept per op duration (LOAD/STORE every 2 cycles, ADD every 3).
- Only one request is in flight at a time, so no hazards.

Test Plan:
- Reset: assert rst_n=0 mid-FILL (len=7, addr=0, data=0x5A) after 3 writes -> outputs return to reset values immediately; mem[0..2]=0x5A, mem[3..7] unchanged; no rsp_valid.
- STORE addr=3 data=0xA5, then LOAD addr=3 -> STORE rsp_valid 2 cycles after accept with rsp_data=0xA5; LOAD rsp_data=0xA5, mem_wen never high during LOAD.
- ADD addr=7, mem[7]=0xF0, data=0x20 -> rsp_data=0xF0, rsp_carry=1, mem[7]=0x10, rsp_valid 3 cycles after accept.
- FILL addr=14, len=3, data=0x3C -> writes addresses 14,15,0,1 in consecutive cycles; mem[2] unchanged; rsp_valid 5 cycles after accept.
- req_valid held high with alternating STORE/LOAD to addr 9 -> accepts every 2 cycles; req_ready low while busy; every LOAD returns the preceding STORE value.
